// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-digit detector and normalizer.
package lzd_pkg;

   // Which bit value is being counted from the MSB side
   typedef enum logic {
      MODE_LZ = 1'b0,   // count leading zeros
      MODE_LO = 1'b1    // count leading ones
   } lzdMode_e;

   // Width needed to hold a count in the range 0..w inclusive
   function automatic int countWidth(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/lzd_tree.sv
// Recursive halving leading-zero counter: count of zero bits from the MSB of x.
// The caller pre-XORs the word with the mode bit, so "matching" bits are zeros.
module lzd_tree
   import lzd_pkg::*;
#(
   parameter  int W  = 16,
   localparam int CW = countWidth(W)
) (
   input  logic [W-1:0]  x,
   output logic [CW-1:0] count
);

   if (W == 1) begin : gLeaf
      // A single bit matches exactly when it is zero
      assign count = ~x;
   end else begin : gNode
      localparam int HW  = W / 2;
      localparam int HCW = countWidth(HW);

      logic [HCW-1:0] hiCount;
      logic [HCW-1:0] loCount;

      lzd_tree #(.W(HW)) uHi (
         .x     (x[W-1:HW]),
         .count (hiCount)
      );

      lzd_tree #(.W(HW)) uLo (
         .x     (x[HW-1:0]),
         .count (loCount)
      );

      // hiCount reaches HW (its MSB set) only when the whole upper half matched,
      // in which case the scan continues into the lower half.
      assign count = hiCount[HCW-1] ? (CW'(HW) + CW'(loCount)) : CW'(hiCount);
   end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero/one counter with normalizing barrel shifter.
// S1 captures the word, its mode and the leading count; S2 captures the
// count, the all-match flag and the word shifted left by the count.
module lzd_norm_pipe
   import lzd_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = countWidth(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   output logic [W-1:0]  out_norm,
   output logic          out_all
);

   localparam int LW = $clog2(W);

   // Stage 1 state
   logic          s1Valid;
   logic [W-1:0]  s1Data;
   lzdMode_e      s1Mode;
   logic [CW-1:0] s1Count;

   // Stage 2 state
   logic          s2Valid;
   logic [CW-1:0] s2Count;
   logic          s2All;
   logic [W-1:0]  s2Norm;

   logic          s1Advance;
   logic [W-1:0]  scanWord;
   logic [CW-1:0] scanCount;
   logic          modeBit;
   logic          allMatch;
   logic [W-1:0]  normWord;
   logic [W-1:0]  shiftStage [LW+1];

   // Flip the word so that bits equal to the mode bit become zeros
   assign scanWord = in_data ^ {W{in_mode}};

   lzd_tree #(.W(W)) uTree (
      .x     (scanWord),
      .count (scanCount)
   );

   // S2 can take a new word when empty or when its word leaves this cycle
   assign s1Advance = !s2Valid || out_ready;
   assign in_ready  = !s1Valid || s1Advance;

   // Stage 1 register: load on input transfer, drain to empty otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s1Data  <= '0;
         s1Mode  <= MODE_LZ;
         s1Count <= '0;
      end else if (in_ready) begin
         s1Valid <= in_valid;
         if (in_valid) begin
            s1Data  <= in_data;
            s1Mode  <= lzdMode_e'(in_mode);
            s1Count <= scanCount;
         end
      end
   end

   // Barrel shifter: level gi shifts by 2**gi when count bit gi is set
   assign shiftStage[0] = s1Data;

   genvar gi;
   for (gi = 0; gi < LW; gi++) begin : gShift
      assign shiftStage[gi+1] = s1Count[gi] ? (shiftStage[gi] << (1 << gi)) : shiftStage[gi];
   end

   // Count bit LW is set only for count == W, where every bit shifts out
   assign normWord = s1Count[LW] ? '0 : shiftStage[LW];

   // Every bit of the captured word equals its mode bit
   assign modeBit  = (s1Mode == MODE_LO);
   assign allMatch = ~|(s1Data ^ {W{modeBit}});

   // Stage 2 register: advance from S1 when the consumer side allows it
   always_ff @(posedge clk) begin
      if (rst) begin
         s2Valid <= 1'b0;
         s2Count <= '0;
         s2All   <= 1'b0;
         s2Norm  <= '0;
      end else if (s1Advance) begin
         s2Valid <= s1Valid;
         if (s1Valid) begin
            s2Count <= s1Count;
            s2All   <= allMatch;
            s2Norm  <= normWord;
         end
      end
   end

   assign out_valid = s2Valid;
   assign out_count = s2Count;
   assign out_norm  = s2Norm;
   assign out_all   = s2All;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: directed W=8 vectors and corner sequences on one
// instance, plus randomized scoreboard runs on W=8, 16 and 64 instances.
module tb_lzd_norm_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int doneCount   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- directed W=8 instance ----------------
   logic       aRst;
   logic       aInValid;
   logic       aInReady;
   logic [7:0] aInData;
   logic       aInMode;
   logic       aOutValid;
   logic       aOutReady;
   logic [3:0] aOutCount;
   logic [7:0] aOutNorm;
   logic       aOutAll;

   lzd_norm_pipe #(.W(8)) dutA (
      .clk       (clk),
      .rst       (aRst),
      .in_valid  (aInValid),
      .in_ready  (aInReady),
      .in_data   (aInData),
      .in_mode   (aInMode),
      .out_valid (aOutValid),
      .out_ready (aOutReady),
      .out_count (aOutCount),
      .out_norm  (aOutNorm),
      .out_all   (aOutAll)
   );

   typedef struct {
      logic [7:0] data;
      logic       mode;
      logic [3:0] cnt;
      logic [7:0] norm;
      logic       all;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   initial begin
      logic [7:0] streamWords [4];
      logic [3:0] heldCount;
      logic [7:0] heldNorm;
      logic       heldAll;
      logic       stalled;
      logic       sawLow;
      int         idx;
      int         outs;

      vecs[0]  = '{8'h01, 1'b0, 4'd7, 8'h80, 1'b0};
      vecs[1]  = '{8'h00, 1'b0, 4'd8, 8'h00, 1'b1};
      vecs[2]  = '{8'hFF, 1'b1, 4'd8, 8'h00, 1'b1};
      vecs[3]  = '{8'hE5, 1'b1, 4'd3, 8'h28, 1'b0};
      vecs[4]  = '{8'hE5, 1'b0, 4'd0, 8'hE5, 1'b0};
      vecs[5]  = '{8'h10, 1'b0, 4'd3, 8'h80, 1'b0};
      vecs[6]  = '{8'h7F, 1'b1, 4'd0, 8'h7F, 1'b0};
      vecs[7]  = '{8'h0F, 1'b0, 4'd4, 8'hF0, 1'b0};
      vecs[8]  = '{8'hF0, 1'b1, 4'd4, 8'h00, 1'b0};
      vecs[9]  = '{8'h3C, 1'b0, 4'd2, 8'hF0, 1'b0};
      vecs[10] = '{8'hFE, 1'b1, 4'd7, 8'h00, 1'b0};

      streamWords[0] = 8'h10;
      streamWords[1] = 8'h20;
      streamWords[2] = 8'h40;
      streamWords[3] = 8'h80;

      // Reset state
      aRst = 1'b1; aInValid = 1'b0; aInData = '0; aInMode = 1'b0; aOutReady = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(aOutValid), 64'd0);
      check("reset_out_count", 64'(aOutCount), 64'd0);
      check("reset_out_norm", 64'(aOutNorm), 64'd0);
      check("reset_out_all", 64'(aOutAll), 64'd0);
      aRst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 64'(aInReady), 64'd1);

      // Table vectors back-to-back: word k emerges at cycle k+2
      for (int k = 0; k < NVEC + 2; k++) begin
         if (k < NVEC) begin
            aInValid = 1'b1; aInData = vecs[k].data; aInMode = vecs[k].mode;
         end else begin
            aInValid = 1'b0;
         end
         #1;
         if (k < NVEC) check("vec_in_ready", 64'(aInReady), 64'd1);
         if (k >= 2) begin
            check("vec_out_valid", 64'(aOutValid), 64'd1);
            check("vec_out_count", 64'(aOutCount), 64'(vecs[k-2].cnt));
            check("vec_out_norm", 64'(aOutNorm), 64'(vecs[k-2].norm));
            check("vec_out_all", 64'(aOutAll), 64'(vecs[k-2].all));
            $display("vec %0d: data=0x%02h mode=%0d count=%0d norm=0x%02h all=%0d",
                     k - 2, vecs[k-2].data, vecs[k-2].mode, aOutCount, aOutNorm, aOutAll);
         end else begin
            check("vec_latency_no_early_valid", 64'(aOutValid), 64'd0);
         end
         @(negedge clk);
      end
      aInValid = 1'b0;
      repeat (2) @(negedge clk);

      // Stream with out_ready low for cycles 3-5
      idx = 0; outs = 0; sawLow = 1'b0; stalled = 1'b0;
      heldCount = '0; heldNorm = '0; heldAll = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (stalled) begin
            check("stall_hold_valid", 64'(aOutValid), 64'd1);
            check("stall_hold_count", 64'(aOutCount), 64'(heldCount));
            check("stall_hold_norm", 64'(aOutNorm), 64'(heldNorm));
            check("stall_hold_all", 64'(aOutAll), 64'(heldAll));
         end
         aOutReady = !(c >= 3 && c <= 5);
         aInValid  = (idx < 4);
         aInData   = (idx < 4) ? streamWords[idx] : 8'h00;
         aInMode   = 1'b0;
         #1;
         if (!aInReady) sawLow = 1'b1;
         if (aOutValid && aOutReady) begin
            if (outs < 4) begin
               check("stream_count", 64'(aOutCount), 64'(3 - outs));
               check("stream_norm", 64'(aOutNorm), 64'h80);
            end else begin
               check("stream_extra_output", 64'd1, 64'd0);
            end
            $display("stream cycle %0d: out %0d count=%0d norm=0x%02h", c, outs, aOutCount, aOutNorm);
            outs++;
         end
         stalled   = aOutValid && !aOutReady;
         heldCount = aOutCount; heldNorm = aOutNorm; heldAll = aOutAll;
         if (aInValid && aInReady) idx++;
      end
      aInValid = 1'b0;
      check("stream_outputs_total", 64'(outs), 64'd4);
      check("stream_in_ready_fell", 64'(sawLow), 64'd1);

      // Reset while both stages hold words, with a word presented that cycle
      @(negedge clk);
      aOutReady = 1'b0;
      aInValid = 1'b1; aInData = 8'h03; aInMode = 1'b0;
      @(negedge clk);
      aInData = 8'h04;
      @(negedge clk);
      check("full_out_valid", 64'(aOutValid), 64'd1);
      check("full_in_ready", 64'(aInReady), 64'd0);
      aInData = 8'h55; aRst = 1'b1;
      @(negedge clk);
      aRst = 1'b0; aInValid = 1'b0; aOutReady = 1'b1;
      #1;
      check("midrst_out_valid", 64'(aOutValid), 64'd0);
      check("midrst_in_ready", 64'(aInReady), 64'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("midrst_no_ghost", 64'(aOutValid), 64'd0);
      end
      aInValid = 1'b1; aInData = 8'h01; aInMode = 1'b0;
      @(negedge clk);
      aInValid = 1'b0;
      check("post_rst_latency", 64'(aOutValid), 64'd0);
      @(negedge clk);
      check("post_rst_valid", 64'(aOutValid), 64'd1);
      check("post_rst_count", 64'(aOutCount), 64'd7);
      check("post_rst_norm", 64'(aOutNorm), 64'h80);
      check("post_rst_all", 64'(aOutAll), 64'd0);
      $display("post-reset word: count=%0d norm=0x%02h", aOutCount, aOutNorm);

      // Wait for the random runs, bounded
      for (int t = 0; t < 60000 && doneCount < 3; t++) @(negedge clk);
      check("random_runs_done", 64'(doneCount), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // ---------------- randomized scoreboard runs ----------------
   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : gRand
      localparam int WW  = (gi == 0) ? 8 : ((gi == 1) ? 16 : 64);
      localparam int CWW = $clog2(WW) + 1;

      logic           rRst;
      logic           rInValid;
      logic           rInReady;
      logic [WW-1:0]  rInData;
      logic           rInMode;
      logic           rOutValid;
      logic           rOutReady;
      logic [CWW-1:0] rOutCount;
      logic [WW-1:0]  rOutNorm;
      logic           rOutAll;

      lzd_norm_pipe #(.W(WW)) dutR (
         .clk       (clk),
         .rst       (rRst),
         .in_valid  (rInValid),
         .in_ready  (rInReady),
         .in_data   (rInData),
         .in_mode   (rInMode),
         .out_valid (rOutValid),
         .out_ready (rOutReady),
         .out_count (rOutCount),
         .out_norm  (rOutNorm),
         .out_all   (rOutAll)
      );

      // Reference: scan from the MSB while bits equal the mode bit
      task automatic refModel(input logic [WW-1:0] d, input logic m,
                              output int c, output logic [WW-1:0] n);
         c = 0;
         while (c < WW && d[WW-1-c] == m) c++;
         n = (c == WW) ? '0 : (d << c);
      endtask

      int            qCount [$];
      logic [WW-1:0] qNorm  [$];

      initial begin
         int            sent;
         int            got;
         int            cyc;
         int            expC;
         logic [WW-1:0] expN;
         logic [WW-1:0] v;
         logic          stalled;
         logic [CWW-1:0] heldCount;
         logic [WW-1:0] heldNorm;

         rRst = 1'b1; rInValid = 1'b0; rInData = '0; rInMode = 1'b0; rOutReady = 1'b0;
         repeat (3) @(negedge clk);
         rRst = 1'b0;
         sent = 0; got = 0; cyc = 0; stalled = 1'b0;
         heldCount = '0; heldNorm = '0;

         while ((sent < 1000 || qCount.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
               check($sformatf("rand%0d_stall_valid", WW), 64'(rOutValid), 64'd1);
               check($sformatf("rand%0d_stall_count", WW), 64'(rOutCount), 64'(heldCount));
               check($sformatf("rand%0d_stall_norm", WW), 64'(rOutNorm), 64'(heldNorm));
            end
            v = WW'({$urandom, $urandom});
            v = v >> $urandom_range(0, WW);
            rInMode   = 1'($urandom_range(0, 1));
            rInData   = rInMode ? ~v : v;
            rInValid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rOutReady = ($urandom_range(0, 3) != 0);
            #1;
            if (rOutValid && rOutReady) begin
               if (qCount.size() == 0) begin
                  check($sformatf("rand%0d_unexpected_output", WW), 64'd1, 64'd0);
               end else begin
                  expC = qCount.pop_front();
                  expN = qNorm.pop_front();
                  check($sformatf("rand%0d_count", WW), 64'(rOutCount), 64'(expC));
                  check($sformatf("rand%0d_norm", WW), 64'(rOutNorm), 64'(expN));
                  check($sformatf("rand%0d_all", WW), 64'(rOutAll), 64'(expC == WW));
               end
               got++;
            end
            stalled   = rOutValid && !rOutReady;
            heldCount = rOutCount;
            heldNorm  = rOutNorm;
            if (rInValid && rInReady) begin
               refModel(rInData, rInMode, expC, expN);
               qCount.push_back(expC);
               qNorm.push_back(expN);
               sent++;
            end
         end
         rInValid = 1'b0;
         rOutReady = 1'b1;
         repeat (3) @(negedge clk);
         check($sformatf("rand%0d_words_out", WW), 64'(got), 64'd1000);
         check($sformatf("rand%0d_drained", WW), 64'(rOutValid), 64'd0);
         $display("random W=%0d: sent=%0d received=%0d cycles=%0d", WW, sent, got, cyc);
         doneCount++;
      end
   end

endmodule
